// File: rtl/data_store_buffer_if.sv
// Core-side and bridge-side SRAM-like ports of data_store_buffer.
// The buffer is the slave on dsb_cpu_if and the master on dsb_mem_if.
interface dsb_cpu_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_wr, cpu_size, cpu_addr, cpu_wstrb, cpu_wdata,
    input  cpu_addr_ok, cpu_data_ok, cpu_rdata
  );
  modport slave (
    input  cpu_req, cpu_wr, cpu_size, cpu_addr, cpu_wstrb, cpu_wdata,
    output cpu_addr_ok, cpu_data_ok, cpu_rdata
  );
endinterface

interface dsb_mem_if;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );
  modport slave (
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the core data port and the AXI bridge.
// Optional store merging into the youngest entry: define STORE_BUF_MERGE_EN.
module data_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic       aclk,
  input  logic       aresetn,
  dsb_cpu_if.slave   cpu,
  dsb_mem_if.master  mem
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;
  state_t state;

  logic [31:0]      e_addr  [DEPTH];
  logic [1:0]       e_size  [DEPTH];
  logic [3:0]       e_wstrb [DEPTH];
  logic [31:0]      e_wdata [DEPTH];
  logic [DEPTH-1:0] e_valid;

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             ack_q;
  logic             rd_busy;
  logic [31:0]      rd_addr;
  logic [1:0]       rd_size;

  logic addr_hit, merge_hit, full;
  logic store_ok, load_ok, push, merge, pop, rd_done;

  always_comb begin
    addr_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (e_valid[i] && (e_addr[i][31:2] == cpu.cpu_addr[31:2])) addr_hit = 1'b1;
    end
  end

`ifdef STORE_BUF_MERGE_EN
  logic [PTR_W-1:0] young;
  logic             head_busy;
  assign young = tail - PTR_W'(1);
  // IDLE with stores queued and no load waiting latches the head into mem_* on
  // this edge, so the head is already committed and must not change.
  assign head_busy = (state == WR_REQ) || (state == WR_WAIT) ||
                     ((state == IDLE) && !rd_busy && (count != '0));
  assign merge_hit = e_valid[young] &&
                     (e_addr[young][31:2] == cpu.cpu_addr[31:2]) &&
                     !((young == head) && head_busy);
`else
  assign merge_hit = 1'b0;
`endif

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign store_ok = cpu.cpu_req && cpu.cpu_wr && !rd_busy && (!full || merge_hit);
  assign load_ok  = cpu.cpu_req && !cpu.cpu_wr && !rd_busy && !addr_hit;
  assign push     = aresetn && store_ok && !merge_hit;
  assign merge    = aresetn && store_ok && merge_hit;
  assign pop      = (state == WR_WAIT) && mem.mem_data_ok;
  assign rd_done  = (state == RD_WAIT) && mem.mem_data_ok;

  assign cpu.cpu_addr_ok = aresetn && (store_ok || load_ok);
  assign cpu.cpu_data_ok = ack_q || rd_done;
  assign cpu.cpu_rdata   = rd_done ? mem.mem_rdata : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      ack_q   <= 1'b0;
      rd_busy <= 1'b0;
      rd_addr <= '0;
      rd_size <= '0;
    end else begin
      ack_q <= push || merge;
      if (push) begin
        e_valid[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (load_ok) begin
        rd_busy <= 1'b1;
        rd_addr <= cpu.cpu_addr;
        rd_size <= cpu.cpu_size;
      end else if (rd_done) begin
        rd_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      e_addr[tail]  <= cpu.cpu_addr;
      e_size[tail]  <= cpu.cpu_size;
      e_wstrb[tail] <= cpu.cpu_wstrb;
      e_wdata[tail] <= cpu.cpu_wdata;
    end
`ifdef STORE_BUF_MERGE_EN
    if (merge) begin
      e_addr[young]  <= {e_addr[young][31:2], 2'b00};
      e_size[young]  <= 2'd2;
      e_wstrb[young] <= e_wstrb[young] | cpu.cpu_wstrb;
      for (int unsigned b = 0; b < 4; b++) begin
        if (cpu.cpu_wstrb[b]) e_wdata[young][8*b +: 8] <= cpu.cpu_wdata[8*b +: 8];
      end
    end
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_size  <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_busy) begin
            state         <= RD_REQ;
            mem.mem_req   <= 1'b1;
            mem.mem_wr    <= 1'b0;
            mem.mem_size  <= rd_size;
            mem.mem_addr  <= rd_addr;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
          end else if (count != '0) begin
            state         <= WR_REQ;
            mem.mem_req   <= 1'b1;
            mem.mem_wr    <= 1'b1;
            mem.mem_size  <= e_size[head];
            mem.mem_addr  <= e_addr[head];
            mem.mem_wstrb <= e_wstrb[head];
            mem.mem_wdata <= e_wdata[head];
          end
        end
        RD_REQ, WR_REQ: begin
          if (mem.mem_addr_ok) begin
            state         <= (state == RD_REQ) ? RD_WAIT : WR_WAIT;
            mem.mem_req   <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_size  <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem.mem_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer: directed sequences, a vector
// table of accept decisions, and randomized traffic against a queue model.
module tb_data_store_buffer;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  dsb_cpu_if cpu ();
  dsb_mem_if mem ();

  data_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .cpu     (cpu),
    .mem     (mem)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic        exp_ok;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } ent_t;

  // Reference model state for the randomized phase
  ent_t        sq[$];
  bit          m_ld, m_ld_iss, m_out, m_out_wr, m_ack;
  logic [31:0] m_ld_addr;
  logic [1:0]  m_ld_size;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_in();
    cpu.cpu_req = 0; cpu.cpu_wr = 0; cpu.cpu_size = 0; cpu.cpu_addr = 0;
    cpu.cpu_wstrb = 0; cpu.cpu_wdata = 0;
    mem.mem_addr_ok = 0; mem.mem_data_ok = 0; mem.mem_rdata = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [3:0] w, input logic [31:0] d);
    cpu.cpu_req = 1; cpu.cpu_wr = 1; cpu.cpu_addr = a; cpu.cpu_size = s;
    cpu.cpu_wstrb = w; cpu.cpu_wdata = d;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s);
    cpu.cpu_req = 1; cpu.cpu_wr = 0; cpu.cpu_addr = a; cpu.cpu_size = s;
    cpu.cpu_wstrb = 0; cpu.cpu_wdata = 0;
  endtask

  task automatic do_reset();
    idle_in();
    aresetn = 0;
    store(32'h1C00_0010, 2'd2, 4'hF, 32'h1111_2222);
    #1;
    chk("rst_addr_ok", cpu.cpu_addr_ok, 0);
    chk("rst_data_ok", cpu.cpu_data_ok, 0);
    chk("rst_mem_req", mem.mem_req, 0);
    chk("rst_mem_addr", mem.mem_addr, 0);
    repeat (2) cycle();
    idle_in();
    aresetn = 1;
    cycle();
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    #1;
    while (!mem.mem_req && n < 20) begin
      cycle(); #1; n++;
    end
    chk(name, mem.mem_req, 1);
  endtask

  task automatic serve_write(input string name, input logic [31:0] a, input logic [1:0] s,
                             input logic [3:0] w, input logic [31:0] d);
    wait_req({name, "_req"});
    chk({name, "_wr"}, mem.mem_wr, 1);
    chk({name, "_addr"}, mem.mem_addr, a);
    chk({name, "_size"}, mem.mem_size, s);
    chk({name, "_wstrb"}, mem.mem_wstrb, w);
    chk({name, "_wdata"}, mem.mem_wdata, d);
    mem.mem_addr_ok = 1;
    cycle();
    mem.mem_addr_ok = 0; mem.mem_data_ok = 1;
    cycle();
    mem.mem_data_ok = 0;
    #1;
  endtask

  task automatic rnd_step(input bit allow_req);
    bit hit, exp_ok, rd_resp, exp_dok;
    cycle();
    cpu.cpu_req   = allow_req && ($urandom_range(2) != 0);
    cpu.cpu_wr    = 1'($urandom_range(1));
    cpu.cpu_addr  = 32'h8000_0000 + 32'($urandom_range(5)) * 4 + 32'($urandom_range(3));
    cpu.cpu_size  = 2'($urandom_range(2));
    cpu.cpu_wstrb = 4'($urandom_range(15));
    cpu.cpu_wdata = $urandom;
    mem.mem_addr_ok = ($urandom_range(2) == 0);
    mem.mem_data_ok = m_out ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
    mem.mem_rdata   = $urandom;
    #1;
    hit = 0;
    foreach (sq[i]) if (sq[i].addr[31:2] == cpu.cpu_addr[31:2]) hit = 1;
    exp_ok = cpu.cpu_req && !m_ld && (cpu.cpu_wr ? (sq.size() < 4) : !hit);
    chk("rnd_addr_ok", cpu.cpu_addr_ok, exp_ok);
    rd_resp = m_out && !m_out_wr && mem.mem_data_ok;
    exp_dok = m_ack || rd_resp;
    chk("rnd_data_ok", cpu.cpu_data_ok, exp_dok);
    if (exp_dok) chk("rnd_rdata", cpu.cpu_rdata, rd_resp ? mem.mem_rdata : 32'h0);
    if (mem.mem_req) begin
      chk("rnd_one_txn", mem.mem_req & m_out, 0);
      if (mem.mem_wr) begin
        if (sq.size() == 0) chk("rnd_wr_spurious", mem.mem_req, 0);
        else begin
          chk("rnd_wr_addr", mem.mem_addr, sq[0].addr);
          chk("rnd_wr_size", mem.mem_size, sq[0].size);
          chk("rnd_wr_wstrb", mem.mem_wstrb, sq[0].wstrb);
          chk("rnd_wr_wdata", mem.mem_wdata, sq[0].wdata);
        end
      end else begin
        if (!m_ld || m_ld_iss) chk("rnd_rd_spurious", mem.mem_req, 0);
        else begin
          chk("rnd_rd_addr", mem.mem_addr, m_ld_addr);
          chk("rnd_rd_size", mem.mem_size, m_ld_size);
          chk("rnd_rd_wstrb", mem.mem_wstrb, 0);
        end
      end
    end
    // model update for the coming edge
    m_ack = exp_ok && cpu.cpu_wr;
    if (exp_ok) begin
      if (cpu.cpu_wr) sq.push_back('{cpu.cpu_addr, cpu.cpu_size, cpu.cpu_wstrb, cpu.cpu_wdata});
      else begin
        m_ld = 1; m_ld_iss = 0; m_ld_addr = cpu.cpu_addr; m_ld_size = cpu.cpu_size;
      end
    end
    if (m_out && mem.mem_data_ok) begin
      m_out = 0;
      if (m_out_wr) void'(sq.pop_front());
      else m_ld = 0;
    end else if (mem.mem_req && mem.mem_addr_ok) begin
      m_out = 1; m_out_wr = mem.mem_wr;
      if (!mem.mem_wr) m_ld_iss = 1;
    end
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 32'h1C00_0010, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h1C00_0013, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h1C00_0014, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h1C00_000C, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h1C00_0010, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h1C00_0020, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h2C00_0010, 1'b1};

    // Single store, one-cycle bridge handshakes
    do_reset();
    store(32'h1C00_0010, 2'd2, 4'hF, 32'hDEAD_BEEF);
    #1 chk("t1_accept", cpu.cpu_addr_ok, 1);
    cycle();
    cpu.cpu_req = 0;
    #1;
    chk("t1_ack", cpu.cpu_data_ok, 1);
    chk("t1_ack_rdata", cpu.cpu_rdata, 0);
    serve_write("t1_wr", 32'h1C00_0010, 2'd2, 4'hF, 32'hDEAD_BEEF);
    cycle(); #1;
    chk("t1_count", 32'(dut.count), 0);
    chk("t1_no_req", mem.mem_req, 0);

    // Accept decisions against a queued store held by a stalled bridge
    do_reset();
    store(32'h1C00_0010, 2'd2, 4'hF, 32'h0BAD_F00D);
    cycle();
    cpu.cpu_req = 0;
    wait_req("tv_req");
    foreach (vecs[i]) begin
      cycle();
      cpu.cpu_req = vecs[i].req; cpu.cpu_wr = vecs[i].wr; cpu.cpu_addr = vecs[i].addr;
      cpu.cpu_size = 2'd2; cpu.cpu_wstrb = 4'hF;
      #1;
      chk($sformatf("tv%0d_addr_ok", i), cpu.cpu_addr_ok, vecs[i].exp_ok);
      chk($sformatf("tv%0d_data_ok", i), cpu.cpu_data_ok, 0);
      chk($sformatf("tv%0d_mem_addr", i), mem.mem_addr, 32'h1C00_0010);
      cpu.cpu_req = 0;
    end
    serve_write("tv_wr", 32'h1C00_0010, 2'd2, 4'hF, 32'h0BAD_F00D);

    // Fill to DEPTH with the bridge stalled; fifth store waits for the pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      store(32'h1000 + 32'(k) * 4, 2'd2, 4'hF, 32'hA000_0000 + 32'(k));
      #1 chk($sformatf("t2_accept%0d", k), cpu.cpu_addr_ok, 1);
      cycle();
    end
    store(32'h2000, 2'd2, 4'hF, 32'hB000_0000);
    wait_req("t2_req");
    chk("t2_head", mem.mem_addr, 32'h1000);
    repeat (2) begin
      chk("t2_full_stall", cpu.cpu_addr_ok, 0);
      cycle(); #1;
    end
    mem.mem_addr_ok = 1;
    #1 chk("t2_full_addr_ok", cpu.cpu_addr_ok, 0);
    cycle();
    mem.mem_addr_ok = 0; mem.mem_data_ok = 1;
    #1 chk("t2_pop_cycle", cpu.cpu_addr_ok, 0);
    cycle();
    mem.mem_data_ok = 0;
    #1 chk("t2_after_pop", cpu.cpu_addr_ok, 1);
    cycle();
    cpu.cpu_req = 0;
    for (int k = 1; k < 4; k++)
      serve_write($sformatf("t2_wr%0d", k), 32'h1000 + 32'(k) * 4, 2'd2, 4'hF, 32'hA000_0000 + 32'(k));
    serve_write("t2_wr4", 32'h2000, 2'd2, 4'hF, 32'hB000_0000);

    // Load blocked by a queued half-word store in the same word
    do_reset();
    store(32'h1C00_0012, 2'd1, 4'hC, 32'h5678_0000);
    cycle();
    load(32'h1C00_0010, 2'd2);
    wait_req("t3_wr_req");
    repeat (2) begin
      chk("t3_blocked", cpu.cpu_addr_ok, 0);
      cycle(); #1;
    end
    mem.mem_addr_ok = 1;
    cycle();
    mem.mem_addr_ok = 0; mem.mem_data_ok = 1;
    #1 chk("t3_blocked_pop", cpu.cpu_addr_ok, 0);
    cycle();
    mem.mem_data_ok = 0;
    #1 chk("t3_load_accept", cpu.cpu_addr_ok, 1);
    cycle();
    cpu.cpu_req = 0;
    wait_req("t3_rd_req");
    chk("t3_rd_wr", mem.mem_wr, 0);
    chk("t3_rd_addr", mem.mem_addr, 32'h1C00_0010);
    chk("t3_rd_size", mem.mem_size, 2);
    mem.mem_addr_ok = 1;
    cycle();
    mem.mem_addr_ok = 0; mem.mem_data_ok = 1; mem.mem_rdata = 32'h1234_5678;
    #1;
    chk("t3_rd_data_ok", cpu.cpu_data_ok, 1);
    chk("t3_rd_rdata", cpu.cpu_rdata, 32'h1234_5678);
    cycle();
    mem.mem_data_ok = 0;
    #1 chk("t3_resp_once", cpu.cpu_data_ok, 0);

    // Pending load is issued ahead of an older queued store
    do_reset();
    store(32'h300, 2'd2, 4'hF, 32'h3333_3333);
    cycle();
    store(32'h100, 2'd2, 4'hF, 32'h1111_1111);
    #1 chk("t4_st_accept", cpu.cpu_addr_ok, 1);
    cycle();
    load(32'h200, 2'd2);
    #1 chk("t4_ld_accept", cpu.cpu_addr_ok, 1);
    cycle();
    store(32'h400, 2'd2, 4'hF, 32'h4444_4444);
    #1 chk("t4_hold_off", cpu.cpu_addr_ok, 0);
    serve_write("t4_wr300", 32'h300, 2'd2, 4'hF, 32'h3333_3333);
    wait_req("t4_rd_req");
    chk("t4_rd_first", mem.mem_wr, 0);
    chk("t4_rd_addr", mem.mem_addr, 32'h200);
    chk("t4_hold_off2", cpu.cpu_addr_ok, 0);
    mem.mem_addr_ok = 1;
    cycle();
    mem.mem_addr_ok = 0; mem.mem_data_ok = 1; mem.mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("t4_rd_rdata", cpu.cpu_rdata, 32'hCAFE_F00D);
    chk("t4_hold_off3", cpu.cpu_addr_ok, 0);
    cycle();
    mem.mem_data_ok = 0;
    #1 chk("t4_st_after_ld", cpu.cpu_addr_ok, 1);
    cycle();
    cpu.cpu_req = 0;
    serve_write("t4_wr100", 32'h100, 2'd2, 4'hF, 32'h1111_1111);
    serve_write("t4_wr400", 32'h400, 2'd2, 4'hF, 32'h4444_4444);

    // Asynchronous reset during WR_WAIT abandons the queue
    do_reset();
    store(32'h1C00_0020, 2'd2, 4'hF, 32'h2020_2020);
    cycle();
    cpu.cpu_req = 0;
    wait_req("t5_req");
    mem.mem_addr_ok = 1;
    store(32'h1C00_0024, 2'd2, 4'hF, 32'h2424_2424);
    cycle();
    mem.mem_addr_ok = 0;
    store(32'h1C00_0028, 2'd2, 4'hF, 32'h2828_2828);
    #1;
    chk("t5_pre_addr_ok", cpu.cpu_addr_ok, 1);
    chk("t5_pre_data_ok", cpu.cpu_data_ok, 1);
    aresetn = 0;
    #1;
    chk("t5_rst_addr_ok", cpu.cpu_addr_ok, 0);
    chk("t5_rst_data_ok", cpu.cpu_data_ok, 0);
    chk("t5_rst_mem_req", mem.mem_req, 0);
    mem.mem_data_ok = 1;
    cycle();
    cpu.cpu_req = 0;
    aresetn = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      mem.mem_data_ok = k[0];
      #1 chk("t5_no_drain", mem.mem_req, 0);
    end
    mem.mem_data_ok = 0;
    chk("t5_count", 32'(dut.count), 0);

    // Adjacent byte stores behind a stalled blocker: merged or kept apart
    do_reset();
    store(32'h500, 2'd2, 4'hF, 32'h5555_5555);
    cycle();
    cpu.cpu_req = 0;
    wait_req("t6_block");
    store(32'h40, 2'd0, 4'h1, 32'h0000_00AA);
    cycle();
    store(32'h41, 2'd0, 4'h2, 32'h0000_BB00);
    #1 chk("t6_accept", cpu.cpu_addr_ok, 1);
    cycle();
    cpu.cpu_req = 0;
    #1;
`ifdef STORE_BUF_MERGE_EN
    chk("t6_count", 32'(dut.count), 2);
    serve_write("t6_wr500", 32'h500, 2'd2, 4'hF, 32'h5555_5555);
    serve_write("t6_merged", 32'h40, 2'd2, 4'h3, 32'h0000_BBAA);
`else
    chk("t6_count", 32'(dut.count), 3);
    serve_write("t6_wr500", 32'h500, 2'd2, 4'hF, 32'h5555_5555);
    serve_write("t6_wr40", 32'h40, 2'd0, 4'h1, 32'h0000_00AA);
    serve_write("t6_wr41", 32'h41, 2'd0, 4'h2, 32'h0000_BB00);
`endif

`ifndef STORE_BUF_MERGE_EN
    // Randomized traffic against the queue model, then a bounded drain
    do_reset();
    sq.delete();
    m_ld = 0; m_ld_iss = 0; m_out = 0; m_out_wr = 0; m_ack = 0;
    m_ld_addr = 0; m_ld_size = 0;
    for (int k = 0; k < 3000; k++) rnd_step(1'b1);
    n = 0;
    while ((sq.size() != 0 || m_ld || m_out) && n < 400) begin
      rnd_step(1'b0);
      n++;
    end
    cycle(); #1;
    chk("rnd_drained", 32'(dut.count), 32'(sq.size()));
    chk("rnd_model_empty", 32'(sq.size()) + 32'(m_ld), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
